// File: rtl/spike_network.sv
// spike_network: barrier-synchronised spike arbiter for the neuron array.
// Waits for every active neuron to raise en_network, snapshots their spike
// codes, picks one firing neuron by round-robin scan and broadcasts
// {code, id} on spike_in together with a one-cycle networkDone strobe.
module spike_network #(
    parameter int TEN_DATA_WIDTH  = 2,
    parameter int NUM_NEURON      = 128,
    parameter int NEURON_ID_WIDTH = 7,
    parameter int ROUND_CNT_WIDTH = 16
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      en,
    input  logic [NEURON_ID_WIDTH:0]                  active_neuron,
    input  logic [NUM_NEURON-1:0]                     en_network_vec,
    input  logic [NUM_NEURON*TEN_DATA_WIDTH-1:0]      spike_vec,
    output logic [TEN_DATA_WIDTH+NEURON_ID_WIDTH-1:0] spike_in,
    output logic                                      networkDone,
    output logic [ROUND_CNT_WIDTH-1:0]                round_cnt,
    output logic                                      invalid_spike,
    output logic                                      busy
);

    localparam int CW = NEURON_ID_WIDTH + 1;
    localparam logic [CW-1:0]              CNT_ONE   = CW'(1'b1);
    localparam logic [CW-1:0]              CNT_ZERO  = CW'(1'b0);
    localparam logic [ROUND_CNT_WIDTH-1:0] ROUND_ONE = ROUND_CNT_WIDTH'(1'b1);
    localparam logic [TEN_DATA_WIDTH-1:0]  CODE_POS  = TEN_DATA_WIDTH'(2'd1);
    localparam logic [TEN_DATA_WIDTH-1:0]  CODE_NEG  = TEN_DATA_WIDTH'(2'd2);
    localparam logic [TEN_DATA_WIDTH-1:0]  CODE_BAD  = TEN_DATA_WIDTH'(2'd3);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_ALL = 3'd1,
        S_SCAN     = 3'd2,
        S_BCAST    = 3'd3,
        S_WAIT_LOW = 3'd4
    } state_t;

    // Limit a requested neuron count to the number of physical slots.
    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] n);
        if (n > CW'(NUM_NEURON)) begin
            return CW'(NUM_NEURON);
        end else begin
            return n;
        end
    endfunction

    state_t                                         state_r;
    logic [NEURON_ID_WIDTH-1:0]                     ptr_r;
    logic [CW-1:0]                                  cnt_r;
    logic [CW-1:0]                                  n_r;
    logic [NUM_NEURON-1:0][TEN_DATA_WIDTH-1:0]      snap_r;

    logic [CW-1:0]                                  n_live_s;
    logic [NUM_NEURON-1:0]                          mask_live_s;
    logic [NUM_NEURON-1:0]                          mask_round_s;
    logic [NUM_NEURON-1:0][TEN_DATA_WIDTH-1:0]      snap_next_s;
    logic                                           barrier_s;
    logic                                           all_low_s;
    logic [CW-1:0]                                  sum_s;
    logic [CW-1:0]                                  idx_full_s;
    logic [CW-1:0]                                  idx_inc_s;
    logic [NEURON_ID_WIDTH-1:0]                     idx_s;
    logic [NEURON_ID_WIDTH-1:0]                     ptr_next_s;
    logic [TEN_DATA_WIDTH-1:0]                      code_s;
    logic                                           hit_s;
    logic                                           last_s;

    // Active masks (live for the barrier, latched for the rest of the round) and masked snapshot.
    always_comb begin
        n_live_s = clamp_count(active_neuron);
        for (int i = 0; i < NUM_NEURON; i++) begin
            mask_live_s[i]  = (CW'(i) < n_live_s);
            mask_round_s[i] = (CW'(i) < n_r);
            if (mask_live_s[i]) begin
                snap_next_s[i] = spike_vec[i*TEN_DATA_WIDTH +: TEN_DATA_WIDTH];
            end else begin
                snap_next_s[i] = {TEN_DATA_WIDTH{1'b0}};
            end
        end
        barrier_s = &(en_network_vec | ~mask_live_s);
        all_low_s = ~|(en_network_vec & mask_round_s);
    end

    // Round-robin scan index, the entry under it, and the pointer after a hit.
    always_comb begin
        sum_s = CW'(ptr_r) + cnt_r;
        if (sum_s >= n_r) begin
            idx_full_s = sum_s - n_r;
        end else begin
            idx_full_s = sum_s;
        end
        idx_s     = idx_full_s[NEURON_ID_WIDTH-1:0];
        idx_inc_s = idx_full_s + CNT_ONE;
        if (idx_inc_s >= n_r) begin
            ptr_next_s = {NEURON_ID_WIDTH{1'b0}};
        end else begin
            ptr_next_s = idx_inc_s[NEURON_ID_WIDTH-1:0];
        end
        code_s = snap_r[idx_s];
        hit_s  = (code_s == CODE_POS) || (code_s == CODE_NEG);
        last_s = (cnt_r == (n_r - CNT_ONE));
    end

    // Barrier / scan / broadcast state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            ptr_r         <= {NEURON_ID_WIDTH{1'b0}};
            cnt_r         <= CNT_ZERO;
            n_r           <= CNT_ZERO;
            snap_r        <= {(NUM_NEURON*TEN_DATA_WIDTH){1'b0}};
            spike_in      <= {(TEN_DATA_WIDTH+NEURON_ID_WIDTH){1'b0}};
            networkDone   <= 1'b0;
            round_cnt     <= {ROUND_CNT_WIDTH{1'b0}};
            invalid_spike <= 1'b0;
        end else begin
            networkDone <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (en && (n_live_s != CNT_ZERO)) begin
                        state_r <= S_WAIT_ALL;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_WAIT_ALL: begin
                    if (!en || (n_live_s == CNT_ZERO)) begin
                        state_r <= S_IDLE;
                    end else if (barrier_s) begin
                        snap_r  <= snap_next_s;
                        n_r     <= n_live_s;
                        cnt_r   <= CNT_ZERO;
                        // A pointer left over from a larger array restarts at slot 0.
                        if (CW'(ptr_r) >= n_live_s) begin
                            ptr_r <= {NEURON_ID_WIDTH{1'b0}};
                        end else begin
                            ptr_r <= ptr_r;
                        end
                        state_r <= S_SCAN;
                    end else begin
                        state_r <= S_WAIT_ALL;
                    end
                end
                S_SCAN: begin
                    if (hit_s) begin
                        spike_in    <= {code_s, idx_s};
                        ptr_r       <= ptr_next_s;
                        networkDone <= 1'b1;
                        round_cnt   <= round_cnt + ROUND_ONE;
                        state_r     <= S_BCAST;
                    end else begin
                        if (code_s == CODE_BAD) begin
                            invalid_spike <= 1'b1;
                        end else begin
                            invalid_spike <= invalid_spike;
                        end
                        if (last_s) begin
                            spike_in    <= {(TEN_DATA_WIDTH+NEURON_ID_WIDTH){1'b0}};
                            networkDone <= 1'b1;
                            round_cnt   <= round_cnt + ROUND_ONE;
                            state_r     <= S_BCAST;
                        end else begin
                            cnt_r   <= cnt_r + CNT_ONE;
                            state_r <= S_SCAN;
                        end
                    end
                end
                S_BCAST: begin
                    state_r <= S_WAIT_LOW;
                end
                S_WAIT_LOW: begin
                    if (all_low_s) begin
                        state_r <= S_WAIT_ALL;
                    end else begin
                        state_r <= S_WAIT_LOW;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state_r != S_IDLE);

endmodule

// File: tb/tb_spike_network.sv
// Testbench for spike_network: emulates the neuron array handshake, predicts
// each broadcast with a round-robin reference model and checks every
// networkDone strobe from an independent monitor against a scoreboard.
module tb_spike_network;

    localparam int N  = 128;
    localparam int IDW = 7;
    localparam int RW = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             en;
    logic [IDW:0]     active_neuron;
    logic [N-1:0]     en_network_vec;
    logic [2*N-1:0]   spike_vec;
    logic [IDW+1:0]   spike_in;
    logic             networkDone;
    logic [RW-1:0]    round_cnt;
    logic             invalid_spike;
    logic             busy;

    spike_network dut (
        .clk(clk), .reset(reset), .en(en), .active_neuron(active_neuron),
        .en_network_vec(en_network_vec), .spike_vec(spike_vec),
        .spike_in(spike_in), .networkDone(networkDone), .round_cnt(round_cnt),
        .invalid_spike(invalid_spike), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [IDW+1:0] spk;
        logic [RW-1:0]  rc;
        logic           inv;
        int             at;
    } exp_t;
    exp_t sb[$];

    // reference model state
    int        m_ptr = 0;
    int        m_rounds = 0;
    bit        m_inv = 1'b0;
    logic [1:0] codes [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // monitor: every strobe must match the oldest prediction
    always @(negedge clk) begin
        if (networkDone === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_networkDone: got strobe expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("spike_in", 32'(spike_in), 32'(e.spk));
                check("round_cnt", 32'(round_cnt), 32'(e.rc));
                check("invalid_spike", 32'(invalid_spike), 32'(e.inv));
                check("strobe_cycle", 32'(cyc), 32'(e.at));
            end
        end
    end

    task automatic model_reset();
        m_ptr = 0;
        m_rounds = 0;
        m_inv = 1'b0;
    endtask

    // One barrier round; called at a negedge with the DUT in WAIT_ALL or WAIT_LOW with en_network low.
    task automatic run_round(input int n_req, input int holdout, input int hold, input int linger);
        int n, p, k, idx, t;
        bit found;
        exp_t e;
        logic [31:0] nr;
        nr = 32'(n_req);
        active_neuron = nr[IDW:0];
        n = (n_req > N) ? N : n_req;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            spike_vec[2*i +: 2] = codes[i];
            if (i < n) en_network_vec[i] = (i != holdout);
            else       en_network_vec[i] = 1'($urandom_range(0, 1));
        end
        if (holdout >= 0) begin
            repeat (hold) @(negedge clk);
            en_network_vec[holdout] = 1'b1;
        end
        p = cyc + 1;
        // reference: plain round-robin over the snapshot
        if (m_ptr >= n) m_ptr = 0;
        found = 1'b0;
        k = n;
        e.spk = '0;
        for (int j = 0; j < n && !found; j++) begin
            idx = (m_ptr + j) % n;
            if (codes[idx] == 2'd3) begin
                m_inv = 1'b1;
            end else if (codes[idx] != 2'd0) begin
                e.spk = {codes[idx], 7'(idx)};
                m_ptr = (idx + 1) % n;
                k = j + 1;
                found = 1'b1;
            end
        end
        m_rounds++;
        e.rc  = 16'(m_rounds);
        e.inv = m_inv;
        e.at  = p + k;
        sb.push_back(e);
        @(negedge clk);
        // spikes changed after the snapshot must not matter
        for (int i = 0; i < N; i++) spike_vec[2*i +: 2] = 2'($urandom_range(0, 3));
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL round_timeout: got no strobe expected one by cycle %0d", e.at);
            sb.delete();
        end
        repeat (linger) @(negedge clk);
        en_network_vec = '0;
        repeat (2 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic do_reset(input int n_req);
        logic [31:0] nr;
        nr = 32'(n_req);
        @(negedge clk);
        reset = 1'b1;
        en_network_vec = '0;
        active_neuron = nr[IDW:0];
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    task automatic set_codes_random();
        int r;
        for (int i = 0; i < N; i++) begin
            r = $urandom_range(0, 11);
            if (r == 8)       codes[i] = 2'd1;
            else if (r == 9)  codes[i] = 2'd2;
            else if (r == 10) codes[i] = 2'd3;
            else              codes[i] = 2'd0;
        end
    endtask

    initial begin
        int nsel;
        reset = 1'b1;
        en = 1'b0;
        active_neuron = '0;
        en_network_vec = '0;
        spike_vec = '0;
        for (int i = 0; i < N; i++) codes[i] = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_spike_in", 32'(spike_in), 32'h0);
        check("rst_networkDone", 32'(networkDone), 32'h0);
        check("rst_round_cnt", 32'(round_cnt), 32'h0);
        check("rst_invalid", 32'(invalid_spike), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        en = 1'b1;
        active_neuron = 8'd4;
        repeat (3) @(negedge clk);
        check("busy_after_en", 32'(busy), 32'h1);

        // spikes {0,1,0,2}: hit at 1 then at 3 (pointer wraps)
        codes[1] = 2'd1;
        codes[3] = 2'd2;
        run_round(4, -1, 0, 0);
        run_round(4, -1, 0, 0);
        // all silent over eight neurons: miss, latency active_neuron+1
        for (int i = 0; i < N; i++) codes[i] = 2'd0;
        run_round(8, -1, 0, 0);
        // neuron 5 of 6 late, then en_network held high after the strobe
        run_round(6, 5, 6, 10);
        // invalid code at 0, firing at 2, inactive firing neuron 7
        codes[0] = 2'd3;
        codes[2] = 2'd1;
        codes[7] = 2'd1;
        run_round(7, -1, 0, 0);
        // oversized active_neuron is clamped to the array size
        set_codes_random();
        run_round(200, -1, 0, 0);

        // reset in the middle of a long scan
        for (int i = 0; i < N; i++) codes[i] = 2'd0;
        active_neuron = 8'd100;
        @(negedge clk);
        for (int i = 0; i < N; i++) spike_vec[2*i +: 2] = 2'd0;
        en_network_vec = '1;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        en_network_vec = '0;
        @(negedge clk);
        check("scan_rst_busy", 32'(busy), 32'h0);
        check("scan_rst_spike_in", 32'(spike_in), 32'h0);
        check("scan_rst_round_cnt", 32'(round_cnt), 32'h0);
        check("scan_rst_invalid", 32'(invalid_spike), 32'h0);
        check("scan_rst_networkDone", 32'(networkDone), 32'h0);
        // zero active neurons keeps the block idle
        active_neuron = 8'd0;
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("idle_with_zero_active", 32'(busy), 32'h0);
        end

        // randomized segments
        for (int seg = 0; seg < 8; seg++) begin
            nsel = $urandom_range(0, 5);
            case (nsel)
                0: nsel = 1;
                1: nsel = 2;
                2: nsel = 128;
                3: nsel = $urandom_range(129, 255);
                default: nsel = $urandom_range(3, 20);
            endcase
            do_reset(nsel);
            for (int r = 0; r < 6; r++) begin
                set_codes_random();
                run_round(nsel, ($urandom_range(0, 3) == 0) ? 0 : -1, $urandom_range(1, 4), $urandom_range(0, 3));
            end
        end

        // en low in WAIT_ALL returns to IDLE
        en = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_after_en_low", 32'(busy), 32'h0);
        check("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
